alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the combinational 8-bit ALU. Accepts one operation per transaction over a valid/ready input port. Produces a registered result with status flags over a valid/ready output port. Single-cycle ops return one cycle after acceptance; signed multiply runs as an iterative shift-add over WIDTH cycles. Sits between the instruction decoder and the register-file write-back path.

## Interface
- WIDTH, 8: operand/result width in bits, ≥ 4.
- clock_in  input  1  sole clock, rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- in_valid_in  input  1  operation request valid.
- in_ready_out  output  1  block can accept a request this cycle.
- opcode_in  input  3  operation select (encodings in alu_seq_pkg).
- operand_a_in  input  WIDTH  signed operand A.
- operand_b_in  input  WIDTH  signed operand B.
- out_valid_out  output  1  result/flags valid.
- out_ready_in  input  1  consumer accepts result this cycle.
- result_out  output  WIDTH  signed result.
- overflow_out  output  1  signed result did not fit in WIDTH (ADD/SUB/MUL only).
- zero_out  output  1  result_out == 0.
- illegal_out  output  1  opcode not implemented.

## Operation
- Opcodes: ADD 000, SUB 001, MUL 010, EQ 011, GT 100, LT 101. Codes 110 and 111 are illegal.
- Transfer: a request is accepted on a rising edge with in_valid_in & in_ready_out. A result is consumed on a rising edge with out_valid_out & out_ready_in.
- Operands and opcode are latched at acceptance. Later input changes have no effect.
- FSM states:
  - IDLE: in_ready_out=1.
  - MUL_BUSY: iterating; in_ready_out=0.
  - DONE: out_valid_out=1.
- Transitions:
  - IDLE with non-MUL accept → DONE.
  - IDLE with MUL accept → MUL_BUSY.
  - MUL_BUSY after WIDTH iterations → DONE.
  - DONE with consume → IDLE.
  - DONE with consume and in_valid_in: in_ready_out=out_ready_in in DONE, so a new accept in the same cycle goes directly to DONE or MUL_BUSY (back-to-back).
- ADD/SUB: WIDTH+1-bit signed compute. overflow=1 when the result is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]. result = low WIDTH bits (wrap).
- MUL: magnitude shift-add into a 2·WIDTH accumulator, one partial product per cycle. Sign is applied at completion. −2^(WIDTH−1) magnitude is handled exactly. overflow=1 when the full product does not fit WIDTH signed bits. result = low WIDTH bits.
- EQ/GT/LT: result=1 or 0 (signed compare), overflow=0.
- Illegal opcode: result=0, overflow=0, illegal=1. Completes in one cycle like ADD.
- zero_out is computed from the final result_out, including saturated values.
- Outputs stay stable while out_valid_out=1 and out_ready_in=0.

## Timing
- Reset values: state IDLE, in_ready_out=1, out_valid_out=0, result_out=0, all flags 0, accumulator 0.
- Reset is asynchronous and aborts any MUL in progress. No result is produced for the aborted op.
- Latency from acceptance edge to out_valid_out high:
  - Non-MUL ops: 1 cycle.
  - MUL: WIDTH cycles.
- Throughput: one non-MUL op per cycle with out_ready_in held high. One MUL per WIDTH cycles.
- All outputs are registered. There is no combinational path from any input to any output except out_ready_in → in_ready_out in DONE.

## Configuration
- ALU_SEQ_SATURATE_EN defined:
  - ADD/SUB/MUL overflow clamps result_out to 2^(WIDTH−1)−1 (positive overflow) or −2^(WIDTH−1) (negative overflow).
  - overflow_out is still asserted.
- ALU_SEQ_SATURATE_EN undefined: results wrap (low WIDTH bits). No saturation logic is synthesised.

## Structure
- alu_seq_pkg holds:
  - opcode localparams and a typedef enum for the 3-bit opcode;
  - the FSM state typedef (IDLE, MUL_BUSY, DONE);
  - a flags struct {overflow, zero, illegal}.
- One sub-module: alu_seq_mul. It is the iterative signed multiplier with start/done, parametrised by WIDTH, and outputs the 2·WIDTH product.
- The top holds the FSM, single-cycle datapath, saturation and output registers.

## Test plan
- WIDTH=8, ADD 100+27, out_ready high → one cycle later: result 127, overflow 0, zero 0. Then ADD 100+28 → result −128 with overflow 1 (wrap build); 127 with overflow 1 (saturate build).
- MUL 12×−10 → out_valid high exactly 8 cycles after accept: result −120, overflow 0. MUL −128×−1 → overflow 1; result −128 (wrap) or 127 (saturate).
- Hold out_ready low 5 cycles after a SUB 5−5 result → result 0 and zero 1 held stable, in_ready low. Raise out_ready with a new EQ 3==3 valid → back-to-back accept; next cycle result 1.
- Opcode 111, then opcode 110 → result 0, illegal 1, one-cycle latency.
- Assert reset_n_in low 3 cycles into a MUL → out_valid 0 and in_ready 1 immediately (asynchronously). No result after release. The next ADD 1+1 returns 2.
- Sweep GT/LT on (−1, 1) and (1, −1) → GT results 0/1 and LT results 1/0, overflow 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the sequential ALU.
//   - opcode localparams and opcode enum (3-bit)
//   - FSM state enum (S_IDLE, S_MUL_BUSY, S_DONE)
//   - status flags struct {overflow, zero, illegal}
package alu_seq_pkg;

    localparam logic [2:0] OPC_ADD = 3'b000;
    localparam logic [2:0] OPC_SUB = 3'b001;
    localparam logic [2:0] OPC_MUL = 3'b010;
    localparam logic [2:0] OPC_EQ  = 3'b011;
    localparam logic [2:0] OPC_GT  = 3'b100;
    localparam logic [2:0] OPC_LT  = 3'b101;

    // Codes 110 and 111 are deliberately not members: they are illegal.
    typedef enum logic [2:0] {
        OP_ADD = OPC_ADD,
        OP_SUB = OPC_SUB,
        OP_MUL = OPC_MUL,
        OP_EQ  = OPC_EQ,
        OP_GT  = OPC_GT,
        OP_LT  = OPC_LT
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_BUSY,
        S_DONE
    } state_e;

    typedef struct packed {
        logic overflow;
        logic zero;
        logic illegal;
    } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative signed multiplier (magnitude shift-add, sign applied
// at the end). One partial product is accumulated per cycle; the last one is
// added combinationally while done_o is high so the full product is ready to
// be captured WIDTH-1 edges after the start edge.
// Ports:
//   clk_i, rst_n_i  clock / async active-low reset
//   start_i         load operands and begin (ignored state is overwritten)
//   a_i, b_i        signed operands, sampled when start_i is high
//   done_o          product_o valid this cycle (single-cycle pulse)
//   product_o       full 2*WIDTH signed product
module alu_seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] final_w;

    // Unsigned magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
    assign mag_a = a_i[WIDTH-1] ? ('0 - a_i) : a_i;
    assign mag_b = b_i[WIDTH-1] ? ('0 - b_i) : b_i;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        neg_d    = neg_q;
        if (start_i) begin
            neg_d    = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            acc_d    = mag_b[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
            mcand_d  = {{(WIDTH-1){1'b0}}, mag_a, 1'b0};
            mplier_d = mag_b >> 1;
            cnt_d    = CW'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == CW'(WIDTH-1)) begin
                busy_d = 1'b0;
            end else begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            neg_q    <= neg_d;
        end
    end

    assign done_o    = busy_q && (cnt_q == CW'(WIDTH-1));
    assign final_w   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o = neg_q ? ('0 - final_w) : final_w;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked signed ALU (ADD/SUB/MUL/EQ/GT/LT) with registered
// result and flags. Non-MUL ops land in the output registers on the accept
// edge; MUL runs in alu_seq_mul and lands WIDTH-1 edges later.
// Optional feature: define ALU_SEQ_SATURATE_EN to clamp ADD/SUB/MUL overflow
// to the signed extremes (overflow_out still asserted); otherwise results wrap.
// Ports:
//   clock_in, reset_n_in          clock / async active-low reset
//   in_valid_in, in_ready_out     request handshake
//   opcode_in, operand_a_in/b_in  operation and signed operands
//   out_valid_out, out_ready_in   result handshake
//   result_out                    signed result
//   overflow_out, zero_out, illegal_out  status flags
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock_in,
    input  logic             reset_n_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [2:0]       opcode_in,
    input  logic [WIDTH-1:0] operand_a_in,
    input  logic [WIDTH-1:0] operand_b_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [WIDTH-1:0] result_out,
    output logic             overflow_out,
    output logic             zero_out,
    output logic             illegal_out
);

`ifdef ALU_SEQ_SATURATE_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    flags_t             flags_q, flags_d;
    logic               accept, consume, is_mul, mul_start, mul_done, mul_load;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   sp_res, mul_res;
    logic               sp_ovf, sp_ill, mul_ovf;
    logic [WIDTH:0]     sum_w;

    assign is_mul    = (opcode_in == OPC_MUL);
    assign accept    = in_valid_in & in_ready_out;
    assign consume   = out_valid_out & out_ready_in;
    assign mul_start = accept & is_mul;
    assign mul_load  = (state_q == S_MUL_BUSY) & mul_done;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk_i     (clock_in),
        .rst_n_i   (reset_n_in),
        .start_i   (mul_start),
        .a_i       (operand_a_in),
        .b_i       (operand_b_in),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // State register
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Next state; in DONE an accept always coincides with a consume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = is_mul ? S_MUL_BUSY : S_DONE;
            S_MUL_BUSY: if (mul_done) state_d = S_DONE;
            S_DONE: begin
                if (accept)       state_d = is_mul ? S_MUL_BUSY : S_DONE;
                else if (consume) state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready_out  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_in);
        out_valid_out = (state_q == S_DONE);
    end

    // Single-cycle datapath
    always_comb begin
        sum_w  = '0;
        sp_res = '0;
        sp_ovf = 1'b0;
        sp_ill = 1'b0;
        case (opcode_in)
            OPC_ADD, OPC_SUB: begin
                if (opcode_in == OPC_ADD)
                    sum_w = {operand_a_in[WIDTH-1], operand_a_in} + {operand_b_in[WIDTH-1], operand_b_in};
                else
                    sum_w = {operand_a_in[WIDTH-1], operand_a_in} - {operand_b_in[WIDTH-1], operand_b_in};
                sp_ovf = sum_w[WIDTH] ^ sum_w[WIDTH-1];
                sp_res = sum_w[WIDTH-1:0];
`ifdef ALU_SEQ_SATURATE_EN
                if (sp_ovf) sp_res = sum_w[WIDTH] ? SMIN : SMAX;
`endif
            end
            OPC_EQ: sp_res = {{(WIDTH-1){1'b0}}, operand_a_in == operand_b_in};
            OPC_GT: sp_res = {{(WIDTH-1){1'b0}}, $signed(operand_a_in) > $signed(operand_b_in)};
            OPC_LT: sp_res = {{(WIDTH-1){1'b0}}, $signed(operand_a_in) < $signed(operand_b_in)};
            OPC_MUL: sp_res = '0;
            default: sp_ill = 1'b1;
        endcase
    end

    // Product fits WIDTH signed bits iff its top WIDTH+1 bits are all equal.
    always_comb begin
        mul_ovf = ~((&mul_prod[2*WIDTH-1:WIDTH-1]) | ~(|mul_prod[2*WIDTH-1:WIDTH-1]));
        mul_res = mul_prod[WIDTH-1:0];
`ifdef ALU_SEQ_SATURATE_EN
        if (mul_ovf) mul_res = mul_prod[2*WIDTH-1] ? SMIN : SMAX;
`endif
    end

    // Output register load
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (accept && !is_mul) begin
            result_d         = sp_res;
            flags_d.overflow = sp_ovf;
            flags_d.illegal  = sp_ill;
            flags_d.zero     = (sp_res == '0);
        end else if (mul_load) begin
            result_d         = mul_res;
            flags_d.overflow = mul_ovf;
            flags_d.illegal  = 1'b0;
            flags_d.zero     = (mul_res == '0);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result_out   = result_q;
    assign overflow_out = flags_q.overflow;
    assign zero_out     = flags_q.zero;
    assign illegal_out  = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clock_in;
    logic       reset_n_in;
    logic       in_valid_in;
    logic       in_ready_out;
    logic [2:0] opcode_in;
    logic [7:0] operand_a_in;
    logic [7:0] operand_b_in;
    logic       out_valid_out;
    logic       out_ready_in;
    logic [7:0] result_out;
    logic       overflow_out;
    logic       zero_out;
    logic       illegal_out;

    int unsigned total;
    int unsigned fails;

    alu_seq #(.WIDTH(8)) dut (
        .clock_in      (clock_in),
        .reset_n_in    (reset_n_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .opcode_in     (opcode_in),
        .operand_a_in  (operand_a_in),
        .operand_b_in  (operand_b_in),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .result_out    (result_out),
        .overflow_out  (overflow_out),
        .zero_out      (zero_out),
        .illegal_out   (illegal_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic signed [7:0] a, input logic signed [7:0] b);
        in_valid_in  = 1'b1;
        opcode_in    = op;
        operand_a_in = a;
        operand_b_in = b;
        step();
        in_valid_in  = 1'b0;
        operand_a_in = 8'h5A;
        operand_b_in = 8'hA5;
    endtask

    initial begin
        total = 0;
        fails = 0;
        reset_n_in   = 1'b0;
        in_valid_in  = 1'b0;
        opcode_in    = 3'b000;
        operand_a_in = '0;
        operand_b_in = '0;
        out_ready_in = 1'b1;
        step();
        step();
        chk("rst_in_ready", in_ready_out, 1);
        chk("rst_out_valid", out_valid_out, 0);
        chk("rst_result", $signed(result_out), 0);
        chk("rst_overflow", overflow_out, 0);
        chk("rst_zero", zero_out, 0);
        chk("rst_illegal", illegal_out, 0);
        reset_n_in = 1'b1;
        step();

        // ADD 100+27 then 100+28
        issue(OP_ADD, 100, 27);
        chk("add127_valid", out_valid_out, 1);
        chk("add127_result", $signed(result_out), 127);
        chk("add127_ovf", overflow_out, 0);
        chk("add127_zero", zero_out, 0);
        issue(OP_ADD, 100, 28);
`ifdef ALU_SEQ_SATURATE_EN
        chk("add128_result", $signed(result_out), 127);
`else
        chk("add128_result", $signed(result_out), -128);
`endif
        chk("add128_ovf", overflow_out, 1);

        // MUL 12 * -10: valid in the 8th cycle after accept
        issue(OP_MUL, 12, -10);
        chk("mul_busy_ready", in_ready_out, 0);
        for (int i = 0; i < 6; i++) begin
            chk("mul_busy_valid", out_valid_out, 0);
            step();
        end
        chk("mul_busy_valid_last", out_valid_out, 0);
        step();
        chk("mul_done_valid", out_valid_out, 1);
        chk("mul_neg120_result", $signed(result_out), -120);
        chk("mul_neg120_ovf", overflow_out, 0);

        // MUL -128 * -1 (back-to-back with the consume)
        issue(OP_MUL, -128, -1);
        for (int i = 0; i < 7; i++) step();
        chk("mulmin_valid", out_valid_out, 1);
        chk("mulmin_ovf", overflow_out, 1);
`ifdef ALU_SEQ_SATURATE_EN
        chk("mulmin_result", $signed(result_out), 127);
`else
        chk("mulmin_result", $signed(result_out), -128);
`endif
        step();
        chk("idle_after_consume", out_valid_out, 0);

        // SUB 5-5 held with out_ready low
        out_ready_in = 1'b0;
        issue(OP_SUB, 5, 5);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid_out, 1);
            chk("hold_result", $signed(result_out), 0);
            chk("hold_zero", zero_out, 1);
            chk("hold_in_ready", in_ready_out, 0);
            step();
        end
        out_ready_in = 1'b1;
        in_valid_in  = 1'b1;
        opcode_in    = OP_EQ;
        operand_a_in = 3;
        operand_b_in = 3;
        #1;
        chk("b2b_in_ready", in_ready_out, 1);
        step();
        in_valid_in = 1'b0;
        chk("eq_valid", out_valid_out, 1);
        chk("eq_result", $signed(result_out), 1);
        chk("eq_zero", zero_out, 0);

        // Illegal opcodes
        issue(3'b111, 9, 4);
        chk("ill7_valid", out_valid_out, 1);
        chk("ill7_result", $signed(result_out), 0);
        chk("ill7_illegal", illegal_out, 1);
        chk("ill7_ovf", overflow_out, 0);
        issue(3'b110, -7, 2);
        chk("ill6_result", $signed(result_out), 0);
        chk("ill6_illegal", illegal_out, 1);

        // Reset during MUL
        issue(OP_MUL, 5, 7);
        chk("ill_cleared", illegal_out, 1);
        step();
        step();
        reset_n_in = 1'b0;
        #1;
        chk("arst_valid", out_valid_out, 0);
        chk("arst_in_ready", in_ready_out, 1);
        chk("arst_result", $signed(result_out), 0);
        step();
        step();
        reset_n_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_no_result", out_valid_out, 0);
        end
        issue(OP_ADD, 1, 1);
        chk("add2_valid", out_valid_out, 1);
        chk("add2_result", $signed(result_out), 2);
        chk("add2_illegal", illegal_out, 0);

        // Signed compares
        issue(OP_GT, -1, 1);
        chk("gt_m1_1", $signed(result_out), 0);
        chk("gt_m1_1_zero", zero_out, 1);
        issue(OP_LT, -1, 1);
        chk("lt_m1_1", $signed(result_out), 1);
        chk("lt_m1_1_ovf", overflow_out, 0);
        issue(OP_GT, 1, -1);
        chk("gt_1_m1", $signed(result_out), 1);
        issue(OP_LT, 1, -1);
        chk("lt_1_m1", $signed(result_out), 0);
        chk("lt_1_m1_ovf", overflow_out, 0);
        step();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
